// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: BCD HH:MM:SS countdown with pause/resume and a held finish flag.
module countdown_timer_bcd #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fin,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       cronofin,
    output logic       load_err
);
    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [23:0] t, t_n, t_dec;
    logic tick, zero_next, valid, fin_n, err_n;

    // Tens digits wrap to 5, units to 9; only ever called with a nonzero time.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                r[4*i +: 4] = (v[4*i +: 4] == 4'd0) ? ((i % 2 == 1) ? 4'd5 : 4'd9) : v[4*i +: 4] - 4'd1;
                b = v[4*i +: 4] == 4'd0;
            end
        end
        return r;
    endfunction

    assign t = {hh, mm, ss};
    assign tick = state == RUN && pre == LAST;
    assign t_dec = bcd_dec(t);
    assign zero_next = tick && t_dec == 24'd0;
    assign valid = hh_in <= 8'h23 && hh_in[3:0] <= 4'd9 &&
                   mm_in[7:4] <= 4'd5 && mm_in[3:0] <= 4'd9 &&
                   ss_in[7:4] <= 4'd5 && ss_in[3:0] <= 4'd9;

    always_comb begin
        state_n = state;
        t_n = t;
        pre_n = pre;
        fin_n = cronofin;
        err_n = 1'b0;
        if (state == RUN) begin
            pre_n = tick ? '0 : pre + PW'(1);
            t_n = tick ? t_dec : t;
            if (zero_next) begin
                state_n = DONE;
                fin_n = 1'b1;
            end
        end
        // One pulse acts per cycle, load first; the prescaler keeps counting underneath.
        if (load) begin
            if (valid) begin
                t_n = {hh_in, mm_in, ss_in};
                pre_n = '0;
                fin_n = 1'b0;
                state_n = IDLE;
            end else begin
                err_n = 1'b1;
            end
        end else if (clear_fin) begin
            if (state == DONE) begin
                state_n = IDLE;
                fin_n = 1'b0;
            end
        end else if (stop) begin
            if (state == RUN && !zero_next) state_n = PAUSE;
        end else if (start) begin
            if (state == PAUSE) begin
                state_n = RUN;
            end else if (state == IDLE && t != 24'd0) begin
                state_n = RUN;
                pre_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            {hh, mm, ss} <= 24'd0;
            pre <= '0;
            running <= 1'b0;
            cronofin <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state <= state_n;
            {hh, mm, ss} <= t_n;
            pre <= pre_n;
            running <= state_n == RUN;
            cronofin <= fin_n;
            load_err <= err_n;
        end
    end
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: cycle scoreboard against a seconds-count reference model.
module tb_countdown_timer_bcd;
    localparam int DIV = 10;

    typedef struct {
        logic [26:0] v;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, load, start, stop, clear_fin;
    logic [7:0] hh_in, mm_in, ss_in, hh, mm, ss;
    logic running, cronofin, load_err;

    exp_t q[$];
    string tag = "init";
    int n_checks = 0;
    int n_pass = 0;

    int m_secs, m_ph;
    bit m_run, m_pause, m_fin, m_err;

    countdown_timer_bcd #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk), .rst(rst), .load(load), .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
        .start(start), .stop(stop), .clear_fin(clear_fin), .hh(hh), .mm(mm), .ss(ss),
        .running(running), .cronofin(cronofin), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int x);
        return 8'((x / 10) * 16 + x % 10);
    endfunction

    function automatic int val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v, input int lim);
        return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && val(v) <= lim;
    endfunction

    task automatic chk(input string name, input logic [26:0] got, input logic [26:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got %h:%h:%h run=%b fin=%b err=%b want %h:%h:%h run=%b fin=%b err=%b",
                      name, $time, got[26:19], got[18:11], got[10:3], got[2], got[1], got[0],
                      want[26:19], want[18:11], want[10:3], want[2], want[1], want[0]);
    endtask

    task automatic model_reset();
        m_secs = 0; m_ph = 0; m_run = 0; m_pause = 0; m_fin = 0; m_err = 0;
    endtask

    // Behavioural view: remaining time is a plain seconds count.
    task automatic model_step(input bit ld, input logic [7:0] h, m, s, input bit st, sp, cf);
        bit was_run, was_pause, was_fin;
        int old;
        was_run = m_run; was_pause = m_pause; was_fin = m_fin; old = m_secs;
        m_err = 0;
        if (was_run) begin
            m_ph++;
            if (m_ph == DIV) begin
                m_ph = 0;
                m_secs--;
                if (m_secs == 0) begin m_run = 0; m_fin = 1; end
            end
        end
        if (ld) begin
            if (bcd_ok(h, 23) && bcd_ok(m, 59) && bcd_ok(s, 59)) begin
                m_secs = val(h) * 3600 + val(m) * 60 + val(s);
                m_ph = 0; m_run = 0; m_pause = 0; m_fin = 0;
            end else m_err = 1;
        end else if (cf) begin
            if (was_fin) m_fin = 0;
        end else if (sp) begin
            if (m_run) begin m_run = 0; m_pause = 1; end
        end else if (st) begin
            if (was_pause) begin m_run = 1; m_pause = 0; end
            else if (!was_run && !was_fin && old != 0) begin m_run = 1; m_ph = 0; end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.v = {to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60), m_run, m_fin, m_err};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive(input bit ld, input logic [7:0] h, m, s, input bit st, sp, cf);
        load = ld; hh_in = h; mm_in = m; ss_in = s; start = st; stop = sp; clear_fin = cf;
        model_step(ld, h, m, s, st, sp, cf);
        push_exp();
    endtask

    task automatic step(input bit ld, input logic [7:0] h, m, s, input bit st, sp, cf);
        @(negedge clk);
        drive(ld, h, m, s, st, sp, cf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    endtask

    task automatic ld(input logic [7:0] h, m, s);
        step(1, h, m, s, 0, 0, 0);
    endtask

    task automatic go();
        step(0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 0; load = 0; start = 0; stop = 0; clear_fin = 0;
        model_reset();
        #1;
        chk("reset_async", {hh, mm, ss, running, cronofin, load_err}, 27'd0);
        push_exp();
        @(negedge clk);
        rst = 1;
        drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.tag, {hh, mm, ss, running, cronofin, load_err}, e.v);
            end
        end
    end

    initial begin
        rst = 0; load = 0; start = 0; stop = 0; clear_fin = 0;
        hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00;
        model_reset();
        #3;
        chk("reset_init", {hh, mm, ss, running, cronofin, load_err}, 27'd0);
        @(negedge clk);
        rst = 1;
        tag = "post_reset"; drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tag = "start_on_zero"; go(); idle(3);
        tag = "countdown3"; ld(8'h00, 8'h00, 8'h03); go(); idle(105);
        tag = "done_start_ignored"; go(); step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0); idle(2);
        tag = "clear_plus_start"; step(0, 8'h00, 8'h00, 8'h00, 1, 0, 1); idle(2);
        tag = "clear_in_idle"; step(0, 8'h00, 8'h00, 8'h00, 0, 0, 1); idle(2);
        tag = "borrow_hh"; ld(8'h10, 8'h00, 8'h00); go(); idle(12);
        tag = "borrow_mm"; ld(8'h00, 8'h01, 8'h00); go(); idle(12);
        tag = "pause"; ld(8'h00, 8'h00, 8'h05); go(); idle(14);
        step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0); idle(50);
        go(); idle(40);
        step(0, 8'h00, 8'h00, 8'h00, 0, 0, 1); idle(2);
        tag = "invalid_load"; ld(8'h00, 8'h00, 8'h08); idle(2);
        ld(8'h24, 8'h00, 8'h00); idle(2);
        ld(8'h00, 8'h60, 8'h00); idle(2);
        ld(8'h00, 8'h00, 8'h1A); idle(2);
        tag = "load_beats_stop"; ld(8'h00, 8'h00, 8'h09); go(); idle(3);
        step(1, 8'h00, 8'h00, 8'h07, 0, 1, 0); idle(3); go(); idle(12);
        tag = "mid_reset"; ld(8'h00, 8'h02, 8'h00); go(); idle(13);
        mid_reset();
        tag = "after_reset"; ld(8'h00, 8'h00, 8'h02); go(); idle(25);
        tag = "random";
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] h, m, s;
            int k, x;
            k = int'($urandom_range(0, 3));
            x = int'($urandom_range(0, 40));
            if (k == 0) begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end else if (k == 1) begin
                h = to_bcd(int'($urandom_range(0, 23)));
                m = to_bcd(int'($urandom_range(0, 59)));
                s = to_bcd(int'($urandom_range(0, 59)));
            end else begin
                h = 8'h00; m = to_bcd(x / 60); s = to_bcd(x % 60);
            end
            step($urandom_range(0, 29) == 0, h, m, s, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
        end
        idle(1);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
